// File: rtl/regression_mac_ctrl.sv
// Accumulates sum_x, sum_y, sum_xx and sum_xy over a run of n samples for
// linear regression, sharing one 16x16 multiplier between the two products.
module regression_mac_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    n_samples,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         x,
  input  logic [15:0]         y,
  output logic [16+CNT_W-1:0] sum_x,
  output logic [16+CNT_W-1:0] sum_y,
  output logic [32+CNT_W-1:0] sum_xx,
  output logic [32+CNT_W-1:0] sum_xy,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_MUL_XX = 3'd2,
    S_MUL_XY = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc_s;
  logic [15:0]         x_q, x_d, y_q, y_d;
  logic [16+CNT_W-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [32+CNT_W-1:0] sum_xx_q, sum_xx_d, sum_xy_q, sum_xy_d;
  logic                in_ready_q, busy_q, done_q;
  logic [15:0]         mul_b_s;
  logic [31:0]         product_s;

  // Single shared multiplier: second operand selects between x_r and y_r.
  always_comb begin
    mul_b_s = x_q;
    if (state_q == S_MUL_XY) begin
      mul_b_s = y_q;
    end else begin
      mul_b_s = x_q;
    end
  end

  assign product_s = x_q * mul_b_s;
  assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    sum_x_d  = sum_x_q;
    sum_y_d  = sum_y_q;
    sum_xx_d = sum_xx_q;
    sum_xy_d = sum_xy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d      = n_samples;
          cnt_d    = {CNT_W{1'b0}};
          sum_x_d  = {(16+CNT_W){1'b0}};
          sum_y_d  = {(16+CNT_W){1'b0}};
          sum_xx_d = {(32+CNT_W){1'b0}};
          sum_xy_d = {(32+CNT_W){1'b0}};
          state_d  = (n_samples != {CNT_W{1'b0}}) ? S_LOAD : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          x_d     = x;
          y_d     = y;
          sum_x_d = sum_x_q + {{CNT_W{1'b0}}, x};
          sum_y_d = sum_y_q + {{CNT_W{1'b0}}, y};
          state_d = S_MUL_XX;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_MUL_XX: begin
        sum_xx_d = sum_xx_q + {{CNT_W{1'b0}}, product_s};
        state_d  = S_MUL_XY;
      end
      S_MUL_XY: begin
        sum_xy_d = sum_xy_q + {{CNT_W{1'b0}}, product_s};
        cnt_d    = cnt_inc_s;
        state_d  = (cnt_inc_s == n_q) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; handshake/status flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= {CNT_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      x_q        <= 16'd0;
      y_q        <= 16'd0;
      sum_x_q    <= {(16+CNT_W){1'b0}};
      sum_y_q    <= {(16+CNT_W){1'b0}};
      sum_xx_q   <= {(32+CNT_W){1'b0}};
      sum_xy_q   <= {(32+CNT_W){1'b0}};
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sum_x_q    <= sum_x_d;
      sum_y_q    <= sum_y_d;
      sum_xx_q   <= sum_xx_d;
      sum_xy_q   <= sum_xy_d;
      in_ready_q <= (state_d == S_LOAD);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum_x    = sum_x_q;
  assign sum_y    = sum_y_q;
  assign sum_xx   = sum_xx_q;
  assign sum_xy   = sum_xy_q;

endmodule

// File: tb/tb_regression_mac_ctrl.sv
// Directed self-checking bench for regression_mac_ctrl (CNT_W = 8).
module tb_regression_mac_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  n_samples;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [23:0] sum_x;
  logic [23:0] sum_y;
  logic [39:0] sum_xx;
  logic [39:0] sum_xy;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  regression_mac_ctrl #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n_samples(n_samples),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .sum_x    (sum_x),
    .sum_y    (sum_y),
    .sum_xx   (sum_xx),
    .sum_xy   (sum_xy),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] n);
    start     = 1'b1;
    n_samples = n;
    tick();
    start     = 1'b0;
  endtask

  // Waits (bounded) for in_ready, then presents one sample for a single cycle.
  task automatic feed(input logic [15:0] xv, input logic [15:0] yv);
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL feed_ready_timeout got %b exp 1", in_ready);
    end
    in_valid = 1'b1;
    x        = xv;
    y        = yv;
    tick();
    in_valid = 1'b0;
    x        = 16'd0;
    y        = 16'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; n_samples = 8'd0; in_valid = 1'b0; x = 16'd0; y = 16'd0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000", {in_ready, busy, done});
    end
    checks++;
    if ({sum_x, sum_y, sum_xx, sum_xy} !== 128'd0) begin
      errors++;
      $display("FAIL reset_sums got %0h exp 0", {sum_x, sum_y, sum_xx, sum_xy});
    end
  endtask

  task automatic test_basic();
    start_run(8'd3);
    feed(16'd1, 16'd2);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_in_mul got %b exp 0", in_ready);
    end
    feed(16'd2, 16'd4);
    feed(16'd3, 16'd6);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early1 got %b exp 0", done); end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early2 got %b exp 0", done); end
    tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %b exp 1", done); end
    checks++;
    if (sum_x !== 24'd6) begin errors++; $display("FAIL basic_sum_x got %0d exp 6", sum_x); end
    checks++;
    if (sum_y !== 24'd12) begin errors++; $display("FAIL basic_sum_y got %0d exp 12", sum_y); end
    checks++;
    if (sum_xx !== 40'd14) begin errors++; $display("FAIL basic_sum_xx got %0d exp 14", sum_xx); end
    checks++;
    if (sum_xy !== 40'd28) begin errors++; $display("FAIL basic_sum_xy got %0d exp 28", sum_xy); end
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL basic_after_done got %b exp 00", {done, busy});
    end
    tick();
    tick();
    checks++;
    if (sum_xy !== 40'd28) begin errors++; $display("FAIL basic_hold_xy got %0d exp 28", sum_xy); end
  endtask

  task automatic test_max_values();
    start_run(8'd2);
    feed(16'hFFFF, 16'hFFFF);
    feed(16'hFFFF, 16'hFFFF);
    tick();
    tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL max_done got %b exp 1", done); end
    checks++;
    if (sum_x !== 24'd131070 || sum_y !== 24'd131070) begin
      errors++;
      $display("FAIL max_sum_xy1 got %0d/%0d exp 131070", sum_x, sum_y);
    end
    checks++;
    if (sum_xx !== 40'd8589672450) begin
      errors++; $display("FAIL max_sum_xx got %0d exp 8589672450", sum_xx);
    end
    checks++;
    if (sum_xy !== 40'd8589672450) begin
      errors++; $display("FAIL max_sum_xy got %0d exp 8589672450", sum_xy);
    end
    tick();
  endtask

  task automatic test_zero_n();
    start_run(8'd0);
    checks++;
    if ({done, busy, in_ready} !== 3'b110) begin
      errors++;
      $display("FAIL zero_flags got %b exp 110", {done, busy, in_ready});
    end
    checks++;
    if ({sum_x, sum_y, sum_xx, sum_xy} !== 128'd0) begin
      errors++;
      $display("FAIL zero_sums got %0h exp 0", {sum_x, sum_y, sum_xx, sum_xy});
    end
    tick();
    checks++;
    if ({done, busy, in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL zero_after got %b exp 000", {done, busy, in_ready});
    end
  endtask

  task automatic test_stall();
    // A sample offered while idle must be ignored.
    in_valid = 1'b1; x = 16'd100; y = 16'd100;
    tick();
    in_valid = 1'b0;
    start_run(8'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({in_ready, busy} !== 2'b11) begin
        errors++;
        $display("FAIL stall_ready cyc %0d got %b exp 11", i, {in_ready, busy});
      end
    end
    feed(16'd10, 16'd3);
    feed(16'd7, 16'd5);
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL stall_done_early got %b exp 0", done); end
    tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL stall_done got %b exp 1", done); end
    checks++;
    if (sum_x !== 24'd17 || sum_y !== 24'd8) begin
      errors++; $display("FAIL stall_sum_x_y got %0d/%0d exp 17/8", sum_x, sum_y);
    end
    checks++;
    if (sum_xx !== 40'd149) begin errors++; $display("FAIL stall_sum_xx got %0d exp 149", sum_xx); end
    checks++;
    if (sum_xy !== 40'd65) begin errors++; $display("FAIL stall_sum_xy got %0d exp 65", sum_xy); end
    tick();
  endtask

  task automatic test_reset_abort();
    int done_seen;
    start_run(8'd4);
    feed(16'd1, 16'd1);
    feed(16'd2, 16'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL abort_flags got %b exp 000", {in_ready, busy, done});
    end
    checks++;
    if ({sum_x, sum_y, sum_xx, sum_xy} !== 128'd0) begin
      errors++;
      $display("FAIL abort_sums got %0h exp 0", {sum_x, sum_y, sum_xx, sum_xy});
    end
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", done_seen); end
    start_run(8'd1);
    feed(16'd5, 16'd7);
    tick();
    tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL fresh_done got %b exp 1", done); end
    checks++;
    if ({sum_x, sum_y, sum_xx, sum_xy} !== {24'd5, 24'd7, 40'd25, 40'd35}) begin
      errors++;
      $display("FAIL fresh_sums got %0d %0d %0d %0d exp 5 7 25 35", sum_x, sum_y, sum_xx, sum_xy);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    start_run(8'd2);
    start     = 1'b1;
    n_samples = 8'd1;
    feed(16'd4, 16'd1);
    n_samples = 8'd5;
    feed(16'd3, 16'd2);
    start = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL busy_start_done_early got %b exp 0", done); end
    tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL busy_start_done got %b exp 1", done); end
    checks++;
    if ({sum_x, sum_y, sum_xx, sum_xy} !== {24'd7, 24'd3, 40'd25, 40'd10}) begin
      errors++;
      $display("FAIL busy_start_sums got %0d %0d %0d %0d exp 7 3 25 10", sum_x, sum_y, sum_xx, sum_xy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %b exp 0", busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_max_values();
    test_zero_n();
    test_stall();
    test_reset_abort();
    test_start_while_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
